// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl -- MEM-stage data-memory controller.
//
// Turns a load/store from the MEM stage into one transaction on a simple
// word-wide, big-endian data bus. The pipeline is stalled while the access
// is outstanding. Load data is extracted and sign- or zero-extended before
// it is handed to the MEM/WB register.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   mem_req/mem_we       access request / store select from the MEM stage
//   mem_op               size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   mem_addr/mem_wdata   byte address / right-justified store data
//   w_reg_*_in           write-back request arriving from EX/MEM
//   w_reg_*_out          write-back request forwarded to MEM/WB
//   stall_req            freeze the front of the pipe, bubble into MEM/WB
//   bus_req/bus_we       registered bus request and write strobe
//   bus_addr/bus_sel     registered word address and byte enables
//   bus_wdata            registered lane-replicated store data
//   bus_ack/bus_rdata    completion pulse and read word
//   bus_err              one-cycle pulse when the bus times out
//   misalign_exc         one-cycle pulse on a misaligned access
//
// Configuration
//   DMEM_MISALIGN_EXC_EN  when defined, misaligned halfword/word accesses
//                         skip the bus and raise misalign_exc. When it is
//                         undefined, the low address bits are ignored and
//                         misalign_exc is tied low.
// ---------------------------------------------------------------------------
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  w_reg_addr_in,
  input  logic [31:0] w_reg_data_in,
  input  logic        w_reg_en_in,
  output logic [4:0]  w_reg_addr_out,
  output logic [31:0] w_reg_data_out,
  output logic        w_reg_en_out,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  tmo_r;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [3:0]  bus_sel_r;
  logic [31:0] bus_wdata_r;
  logic        bus_err_r;
  logic [31:0] load_data_r;
  logic        fail_r;       // access ended without a usable result
  logic        misalign_s;

  // Byte enables for a given size (mem_op[1:0]) and byte offset.
  // Lane 0 is the most significant byte (big-endian).
  function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                          input logic [1:0] offs);
    logic [3:0] sel_v;
    case (size)
      2'b00:   sel_v = 4'b1000 >> offs;
      2'b01:   sel_v = offs[1] ? 4'b0011 : 4'b1100;
      2'b10:   sel_v = 4'b1111;
      default: sel_v = 4'b1111;
    endcase
    return sel_v;
  endfunction

  // Replicate the store datum across every lane it could land in, so the
  // byte enables alone pick the destination.
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] data_v;
    case (size)
      2'b00:   data_v = {4{wdata[7:0]}};
      2'b01:   data_v = {2{wdata[15:0]}};
      2'b10:   data_v = wdata;
      default: data_v = wdata;
    endcase
    return data_v;
  endfunction

  // Pick the addressed byte/halfword out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  offs,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (offs)
      2'b00:   byte_v = rdata[31:24];
      2'b01:   byte_v = rdata[23:16];
      2'b10:   byte_v = rdata[15:8];
      2'b11:   byte_v = rdata[7:0];
      default: byte_v = rdata[7:0];
    endcase
    half_v = offs[1] ? rdata[15:0] : rdata[31:16];
    case (op)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = rdata;
      3'b100:  res_v = {24'h000000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

`ifdef DMEM_MISALIGN_EXC_EN
  logic misalign_exc_r;

  // Detect halfword accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    misalign_s = 1'b0;
    case (mem_op[1:0])
      2'b01:   misalign_s = mem_addr[0];
      2'b10:   misalign_s = (mem_addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end

  // Exception pulse lines up with the DONE cycle of the rejected access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_exc_r <= 1'b0;
    end else begin
      misalign_exc_r <= (state_r == ST_IDLE) && mem_req && misalign_s;
    end
  end

  assign misalign_exc = misalign_exc_r;
`else
  assign misalign_s   = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A timeout at tmo=255 only wins when no ack arrives
  // in that same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_req) begin
          state_nxt_s = misalign_s ? ST_DONE : ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ack || (tmo_r == 8'd255)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus side registers, timeout counter and load data latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_r       <= 8'd0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_sel_r   <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      bus_err_r   <= 1'b0;
      load_data_r <= 32'h0000_0000;
      fail_r      <= 1'b0;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_req && !misalign_s) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= mem_we;
            bus_addr_r  <= {mem_addr[31:2], 2'b00};
            bus_sel_r   <= lane_sel(mem_op[1:0], mem_addr[1:0]);
            bus_wdata_r <= lane_wdata(mem_op[1:0], mem_wdata);
            tmo_r       <= 8'd0;
            fail_r      <= 1'b0;
          end else if (mem_req) begin
            fail_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req_r   <= 1'b0;
            load_data_r <= load_extract(mem_op, mem_addr[1:0], bus_rdata);
            fail_r      <= 1'b0;
          end else if (tmo_r == 8'd255) begin
            bus_req_r <= 1'b0;
            bus_err_r <= 1'b1;
            fail_r    <= 1'b1;
          end else begin
            tmo_r <= tmo_r + 8'd1;
          end
        end
        ST_DONE: begin
          fail_r <= fail_r;
        end
        default: begin
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Stall and write-back forwarding. Loads only write back in DONE, and
  // only when the access completed normally.
  always_comb begin
    w_reg_addr_out = 5'd0;
    w_reg_data_out = 32'h0000_0000;
    w_reg_en_out   = 1'b0;
    stall_req      = 1'b0;
    if (!rst_n) begin
      stall_req = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          w_reg_addr_out = w_reg_addr_in;
          w_reg_data_out = w_reg_data_in;
          w_reg_en_out   = mem_req ? 1'b0 : w_reg_en_in;
          stall_req      = mem_req;
        end
        ST_REQ: begin
          w_reg_addr_out = w_reg_addr_in;
          w_reg_data_out = w_reg_data_in;
          w_reg_en_out   = 1'b0;
          stall_req      = mem_req;
        end
        ST_DONE: begin
          w_reg_addr_out = w_reg_addr_in;
          w_reg_data_out = mem_we ? w_reg_data_in : load_data_r;
          w_reg_en_out   = (!mem_we && !fail_r) ? w_reg_en_in : 1'b0;
          stall_req      = 1'b0;
        end
        default: begin
          stall_req = 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_sel   = bus_sel_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl -- directed self-checking bench for dmem_ctrl.
// Inputs change on the falling edge and outputs are sampled 1 ns after it.
// The bench acts as a bus slave that acks after a chosen number of REQ cycles.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  w_reg_addr_in;
  logic [31:0] w_reg_data_in;
  logic        w_reg_en_in;
  logic [4:0]  w_reg_addr_out;
  logic [31:0] w_reg_data_out;
  logic        w_reg_en_out;
  logic        stall_req;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        misalign_exc;

  int checks_r;
  int failures_r;

  dmem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_op         (mem_op),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .w_reg_addr_in  (w_reg_addr_in),
    .w_reg_data_in  (w_reg_data_in),
    .w_reg_en_in    (w_reg_en_in),
    .w_reg_addr_out (w_reg_addr_out),
    .w_reg_data_out (w_reg_data_out),
    .w_reg_en_out   (w_reg_en_out),
    .stall_req      (stall_req),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_sel        (bus_sel),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .bus_err        (bus_err),
    .misalign_exc   (misalign_exc)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; acks on REQ cycle ack_cyc (0 = never ack).
  task automatic run_access(input string tag, input logic we,
                            input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_cyc,
                            input logic [31:0] rdata,
                            input logic [31:0] exp_addr,
                            input logic [3:0] exp_sel,
                            input logic [31:0] exp_bwdata,
                            input logic [31:0] exp_wb, input logic exp_en,
                            input logic exp_err, input logic exp_mis,
                            input int exp_reqc, input int exp_stalls);
    int          stalls;
    int          reqc;
    logic        seen;
    logic        held;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [3:0]  s0;
    logic        we0;
    @(negedge clk);
    mem_req       = 1'b1;
    mem_we        = we;
    mem_op        = op;
    mem_addr      = addr;
    mem_wdata     = wdata;
    w_reg_addr_in = 5'd9;
    w_reg_data_in = 32'hCAFE_0009;
    w_reg_en_in   = 1'b1;
    bus_rdata     = rdata;
    stalls = 0;
    reqc   = 0;
    seen   = 1'b0;
    held   = 1'b1;
    a0 = 32'h0; wd0 = 32'h0; s0 = 4'h0; we0 = 1'b0;
    #1;
    for (int i = 0; i < 400; i++) begin
      if (!stall_req) break;
      stalls++;
      if (bus_req) begin
        reqc++;
        if (!seen) begin
          a0 = bus_addr; s0 = bus_sel; wd0 = bus_wdata; we0 = bus_we;
          seen = 1'b1;
        end else if ({bus_addr, bus_sel, bus_wdata, bus_we} !== {a0, s0, wd0, we0}) begin
          held = 1'b0;
        end
        bus_ack = (reqc == ack_cyc);
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    bus_ack = 1'b0;
    // Now in the DONE cycle.
    check_val({tag, " stalls"}, stalls, exp_stalls);
    check_val({tag, " req_cycles"}, reqc, exp_reqc);
    if (seen) begin
      check_val({tag, " bus_addr"}, a0, exp_addr);
      check_val({tag, " bus_sel"}, {28'h0, s0}, {28'h0, exp_sel});
      check_val({tag, " bus_we"}, {31'h0, we0}, {31'h0, we});
      check_val({tag, " bus_held"}, {31'h0, held}, 32'h1);
      if (we) check_val({tag, " bus_wdata"}, wd0, exp_bwdata);
    end
    check_val({tag, " stall_done"}, {31'h0, stall_req}, 32'h0);
    check_val({tag, " bus_req_done"}, {31'h0, bus_req}, 32'h0);
    check_val({tag, " wb_addr"}, {27'h0, w_reg_addr_out}, 32'd9);
    check_val({tag, " wb_en"}, {31'h0, w_reg_en_out}, {31'h0, exp_en});
    if (exp_en) check_val({tag, " wb_data"}, w_reg_data_out, exp_wb);
    check_val({tag, " bus_err"}, {31'h0, bus_err}, {31'h0, exp_err});
    check_val({tag, " misalign"}, {31'h0, misalign_exc}, {31'h0, exp_mis});
  endtask

  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_op = 3'b000;
    mem_addr = 32'h0; mem_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    w_reg_addr_in = 5'd3; w_reg_data_in = 32'h5555_AAAA; w_reg_en_in = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_val("rst bus_req", {31'h0, bus_req}, 32'h0);
    check_val("rst bus_addr", bus_addr, 32'h0);
    check_val("rst bus_sel", {28'h0, bus_sel}, 32'h0);
    check_val("rst bus_wdata", bus_wdata, 32'h0);
    check_val("rst bus_err", {31'h0, bus_err}, 32'h0);
    check_val("rst misalign", {31'h0, misalign_exc}, 32'h0);
    check_val("rst stall", {31'h0, stall_req}, 32'h0);
    check_val("rst wb_en", {31'h0, w_reg_en_out}, 32'h0);
    check_val("rst wb_data", w_reg_data_out, 32'h0);
    check_val("rst wb_addr", {27'h0, w_reg_addr_out}, 32'h0);

    // Idle pass-through.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("idle wb_addr", {27'h0, w_reg_addr_out}, 32'd3);
    check_val("idle wb_data", w_reg_data_out, 32'h5555_AAAA);
    check_val("idle wb_en", {31'h0, w_reg_en_out}, 32'h1);
    check_val("idle stall", {31'h0, stall_req}, 32'h0);
    check_val("idle bus_req", {31'h0, bus_req}, 32'h0);

    // tag we op addr wdata ack rdata | addr sel bwdata wb en err mis reqc stalls
    run_access("LW", 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF,
               32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 3, 4);
    run_access("LB", 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h1234_56F0,
               32'h100, 4'b0001, 32'h0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1, 2);
    run_access("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h1234_56F0,
               32'h100, 4'b0001, 32'h0, 32'h0000_00F0, 1'b1, 1'b0, 1'b0, 2, 3);
    run_access("LHU", 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h1234_56F0,
               32'h100, 4'b0011, 32'h0, 32'h0000_56F0, 1'b1, 1'b0, 1'b0, 1, 2);
    run_access("LH", 1'b0, 3'b001, 32'h200, 32'h0, 1, 32'h8001_1234,
               32'h200, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 1, 2);
    run_access("LB0", 1'b0, 3'b000, 32'h204, 32'h0, 1, 32'h7F80_0000,
               32'h204, 4'b1000, 32'h0, 32'h0000_007F, 1'b1, 1'b0, 1'b0, 1, 2);
    run_access("SB", 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 1, 32'h0,
               32'h100, 4'b0100, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0, 1'b0, 1, 2);
    run_access("SH", 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 2, 32'h0,
               32'h100, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0, 1'b0, 2, 3);
    run_access("SW", 1'b1, 3'b010, 32'h104, 32'h1122_3344, 1, 32'h0,
               32'h104, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 1'b0, 1, 2);

    // Timeout: no ack for 256 REQ cycles.
    run_access("TMO", 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0,
               32'h300, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 256, 257);
    // Ack on the very cycle tmo reaches 255 still succeeds.
    run_access("ACK255", 1'b0, 3'b010, 32'h304, 32'h0, 256, 32'h0BAD_F00D,
               32'h304, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 256, 257);
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check_val("err pulse end", {31'h0, bus_err}, 32'h0);

    // Misaligned word load.
`ifdef DMEM_MISALIGN_EXC_EN
    run_access("MIS", 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'h0,
               32'h100, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1);
`else
    run_access("MIS", 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'hA5A5_0001,
               32'h100, 4'b1111, 32'h0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1, 2);
`endif
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check_val("mis pulse end", {31'h0, misalign_exc}, 32'h0);

    // Reset in the middle of REQ, followed by a late ack.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_op = 3'b010; mem_addr = 32'h400;
    w_reg_data_in = 32'h7777_0001; w_reg_en_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("mid bus_req", {31'h0, bus_req}, 32'h1);
    rst_n = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    #1;
    check_val("mrst bus_req", {31'h0, bus_req}, 32'h0);
    check_val("mrst bus_addr", bus_addr, 32'h0);
    check_val("mrst bus_sel", {28'h0, bus_sel}, 32'h0);
    check_val("mrst stall", {31'h0, stall_req}, 32'h0);
    check_val("mrst wb_data", w_reg_data_out, 32'h0);
    check_val("mrst wb_en", {31'h0, w_reg_en_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_val("late ack bus_req", {31'h0, bus_req}, 32'h0);
    check_val("late ack bus_err", {31'h0, bus_err}, 32'h0);
    check_val("late ack stall", {31'h0, stall_req}, 32'h0);
    check_val("late ack wb_data", w_reg_data_out, 32'h7777_0001);
    check_val("late ack wb_en", {31'h0, w_reg_en_out}, 32'h1);

    // Controller is back in IDLE and serves a fresh access normally.
    run_access("POST", 1'b0, 3'b010, 32'h500, 32'h0, 1, 32'h0F0F_0F0F,
               32'h500, 4'b1111, 32'h0, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0, 1, 2);
    @(negedge clk);
    mem_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
